// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

    localparam int unsigned WAIT_CNT_W = 16;

    // Writeback source select; code 3 is reserved and behaves like SEL_ALU.
    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_LINK = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the addressed lane out of the memory word,
// sign- or zero-extends it and flags accesses that are not naturally aligned.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int unsigned  DATA_W = 32,
    localparam int unsigned OFF_W  = $clog2(DATA_W / 8),
    localparam int unsigned BIT_W  = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] rdata,
    input  ld_size_e          size,
    input  logic              is_signed,
    input  logic [OFF_W-1:0]  byte_off,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [DATA_W-1:0] shifted;
    logic [BIT_W-1:0]  msb;
    logic              fill;

    // Shift the addressed lane down to bit 0, then overwrite everything above the field MSB.
    always_comb begin
        shifted  = rdata >> {byte_off, 3'b000};
        msb      = BIT_W'(7);
        misalign = 1'b0;
        unique case (size)
            LD_B: msb = BIT_W'(7);
            LD_H: begin
                msb      = BIT_W'(15);
                misalign = byte_off[0];
            end
            LD_W: begin
                msb      = BIT_W'(31);
                misalign = |byte_off[1:0];
            end
            LD_D: begin
                msb      = BIT_W'(DATA_W - 1);
                // A doubleword does not exist on a 32-bit datapath.
                misalign = (DATA_W != 64) || (|byte_off);
            end
        endcase
        fill = is_signed & shifted[msb];
        data = shifted;
        for (int i = 0; i < DATA_W; i++) begin
            if (i > int'(msb)) begin
                data[i] = fill;
            end
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: selects ALU / load / link data, waits a bounded
// number of cycles for late load data and drives the register-file write port.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned  DATA_W   = 32,
    parameter int unsigned  REG_AW   = 4,
    parameter int unsigned  MAX_WAIT = 15,
    parameter int unsigned  ZERO_REG = 0,
    localparam int unsigned OFF_W    = $clog2(DATA_W / 8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_sel,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [DATA_W-1:0]     in_link,
    input  logic [REG_AW-1:0]     in_rd,
    input  logic                  in_we,
    input  logic [1:0]            in_ld_size,
    input  logic                  in_ld_signed,
    input  logic [OFF_W-1:0]      in_byte_off,
    input  logic                  mem_valid,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  flush,
    output logic                  rf_we,
    output logic [REG_AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  fwd_valid,
    output logic [REG_AW-1:0]     fwd_addr,
    output logic [DATA_W-1:0]     fwd_data,
    output logic                  err_misalign,
    output logic                  err_timeout,
    output logic [WAIT_CNT_W-1:0] wait_cycles
);

    wb_state_e             state_q;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_next;

    // Load instruction parked while waiting for memory data.
    logic [REG_AW-1:0]     lat_rd;
    logic                  lat_we;
    ld_size_e              lat_size;
    logic                  lat_signed;
    logic [OFF_W-1:0]      lat_off;

    logic                  rf_we_q;
    logic [REG_AW-1:0]     rf_waddr_q;
    logic [DATA_W-1:0]     rf_wdata_q;
    logic                  err_misalign_q;
    logic                  err_timeout_q;
    logic [WAIT_CNT_W-1:0] wait_cycles_q;

    ld_size_e              al_size;
    logic                  al_signed;
    logic [OFF_W-1:0]      al_off;
    logic [DATA_W-1:0]     al_data;
    logic                  al_misalign;

    logic                  in_is_load;
    logic [DATA_W-1:0]     in_wdata;
    logic                  in_wr_ok;
    logic                  lat_wr_ok;

    // Decode the incoming instruction and steer the aligner to live or parked load fields.
    always_comb begin
        in_is_load = (in_sel == SEL_MEM);
        in_wdata   = (in_sel == SEL_LINK) ? in_link : in_alu;
        in_wr_ok   = in_we && !((ZERO_REG != 0) && (in_rd == '0));
        lat_wr_ok  = lat_we && !((ZERO_REG != 0) && (lat_rd == '0));
        cnt_next   = cnt_q + WAIT_CNT_W'(1);
        if (state_q == IDLE) begin
            al_size   = ld_size_e'(in_ld_size);
            al_signed = in_ld_signed;
            al_off    = in_byte_off;
        end else begin
            al_size   = lat_size;
            al_signed = lat_signed;
            al_off    = lat_off;
        end
    end

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .rdata     (mem_rdata),
        .size      (al_size),
        .is_signed (al_signed),
        .byte_off  (al_off),
        .data      (al_data),
        .misalign  (al_misalign)
    );

    // FSM with registered write-port and error outputs; rf_we/err_misalign default to a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            lat_rd         <= '0;
            lat_we         <= 1'b0;
            lat_size       <= LD_B;
            lat_signed     <= 1'b0;
            lat_off        <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            err_misalign_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            wait_cycles_q  <= '0;
        end else begin
            rf_we_q        <= 1'b0;
            err_misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && !flush) begin
                        if (in_is_load && !mem_valid) begin
                            lat_rd     <= in_rd;
                            lat_we     <= in_we;
                            lat_size   <= ld_size_e'(in_ld_size);
                            lat_signed <= in_ld_signed;
                            lat_off    <= in_byte_off;
                            cnt_q      <= '0;
                            state_q    <= WAIT_MEM;
                        end else if (in_is_load) begin
                            rf_waddr_q     <= in_rd;
                            rf_wdata_q     <= al_data;
                            rf_we_q        <= in_wr_ok && !al_misalign;
                            err_misalign_q <= al_misalign;
                        end else begin
                            rf_waddr_q <= in_rd;
                            rf_wdata_q <= in_wdata;
                            rf_we_q    <= in_wr_ok;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (wait_cycles_q != '1) begin
                        wait_cycles_q <= wait_cycles_q + WAIT_CNT_W'(1);
                    end
                    if (flush) begin
                        // Flush wins over data arriving in the same cycle.
                        state_q <= IDLE;
                    end else if (mem_valid) begin
                        rf_waddr_q     <= lat_rd;
                        rf_wdata_q     <= al_data;
                        rf_we_q        <= lat_wr_ok && !al_misalign;
                        err_misalign_q <= al_misalign;
                        state_q        <= IDLE;
                    end else if (cnt_next == WAIT_CNT_W'(MAX_WAIT)) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign fwd_valid    = rf_we_q;
    assign fwd_addr     = rf_waddr_q;
    assign fwd_data     = rf_wdata_q;
    assign err_misalign = err_misalign_q;
    assign err_timeout  = err_timeout_q;
    assign wait_cycles  = wait_cycles_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (32-bit datapath, MAX_WAIT=4, ZERO_REG=1).
module tb_wb_stage;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 4;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned ZERO_REG = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_sel;
    logic [31:0]       in_alu;
    logic [31:0]       in_link;
    logic [3:0]        in_rd;
    logic              in_we;
    logic [1:0]        in_ld_size;
    logic              in_ld_signed;
    logic [1:0]        in_byte_off;
    logic              mem_valid;
    logic [31:0]       mem_rdata;
    logic              flush;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic              fwd_valid;
    logic [3:0]        fwd_addr;
    logic [31:0]       fwd_data;
    logic              err_misalign;
    logic              err_timeout;
    logic [15:0]       wait_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .MAX_WAIT (MAX_WAIT),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_alu       (in_alu),
        .in_link      (in_link),
        .in_rd        (in_rd),
        .in_we        (in_we),
        .in_ld_size   (in_ld_size),
        .in_ld_signed (in_ld_signed),
        .in_byte_off  (in_byte_off),
        .mem_valid    (mem_valid),
        .mem_rdata    (mem_rdata),
        .flush        (flush),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout),
        .wait_cycles  (wait_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 0; in_sel = 0; in_alu = 0; in_link = 0; in_rd = 0; in_we = 0;
        in_ld_size = 0; in_ld_signed = 0; in_byte_off = 0;
        mem_valid = 0; mem_rdata = 0; flush = 0;
    endtask

    task automatic apply_reset();
        idle_in();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic drive_load(input logic mv, input logic [31:0] rdata, input logic [1:0] size,
                              input logic sgn, input logic [1:0] off, input logic [3:0] rd);
        in_valid = 1; in_sel = 2'd1; in_we = 1; in_rd = rd;
        in_ld_size = size; in_ld_signed = sgn; in_byte_off = off;
        mem_valid = mv; mem_rdata = rdata;
    endtask

    task automatic test_reset();
        idle_in();
        rst = 1;
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        checks++; if (rf_waddr !== 4'h0) begin errors++; $display("FAIL reset_waddr: got %h want 0", rf_waddr); end
        checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
        checks++; if (fwd_valid !== 1'b0 || fwd_data !== 32'h0) begin errors++; $display("FAIL reset_fwd: got %b/%h want 0/0", fwd_valid, fwd_data); end
        checks++; if (err_misalign !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b/%b want 0/0", err_misalign, err_timeout); end
        checks++; if (wait_cycles !== 16'h0) begin errors++; $display("FAIL reset_wait: got %h want 0", wait_cycles); end
        rst = 0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_alu_select();
        apply_reset();
        in_valid = 1; in_sel = 2'd0; in_alu = 32'd5; mem_rdata = 32'd3; in_rd = 4'd2; in_we = 1;
        tick();
        in_valid = 0;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_we: got %b want 1", rf_we); end
        checks++; if (rf_waddr !== 4'd2) begin errors++; $display("FAIL alu_waddr: got %h want 2", rf_waddr); end
        checks++; if (rf_wdata !== 32'd5) begin errors++; $display("FAIL alu_wdata: got %h want 5", rf_wdata); end
        checks++; if (fwd_valid !== 1'b1 || fwd_addr !== 4'd2 || fwd_data !== 32'd5) begin errors++; $display("FAIL alu_fwd: got %b/%h/%h want 1/2/5", fwd_valid, fwd_addr, fwd_data); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_we_drop: got %b want 0", rf_we); end
        // Link select, then reserved code 3 falls back to the ALU value.
        in_valid = 1; in_sel = 2'd2; in_alu = 32'h5; in_link = 32'h100; in_rd = 4'd3;
        tick();
        checks++; if (rf_wdata !== 32'h100 || rf_we !== 1'b1) begin errors++; $display("FAIL link_wdata: got %h/%b want 100/1", rf_wdata, rf_we); end
        in_sel = 2'd3; in_alu = 32'h77;
        tick();
        in_valid = 0;
        checks++; if (rf_wdata !== 32'h77 || rf_we !== 1'b1) begin errors++; $display("FAIL rsvd_wdata: got %h/%b want 77/1", rf_wdata, rf_we); end
    endtask

    task automatic test_load_immediate();
        logic [31:0] rdv [6];
        logic [1:0]  szv [6];
        logic        sgv [6];
        logic [1:0]  ofv [6];
        logic [31:0] exv [6];
        rdv = '{32'h3, 32'h80, 32'h80, 32'h8F00_0000, 32'h8001_0000, 32'h8001_0000};
        szv = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        sgv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ofv = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd2};
        exv = '{32'h3, 32'hFFFF_FF80, 32'h80, 32'hFFFF_FF8F, 32'hFFFF_8001, 32'h8001};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_load(1'b1, rdv[i], szv[i], sgv[i], ofv[i], 4'(i + 4));
            tick();
            idle_in();
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'(i + 4)) begin errors++; $display("FAIL ldimm_we[%0d]: got %b/%h want 1/%h", i, rf_we, rf_waddr, 4'(i + 4)); end
            checks++; if (rf_wdata !== exv[i]) begin errors++; $display("FAIL ldimm_data[%0d]: got %h want %h", i, rf_wdata, exv[i]); end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_sel = 2'd0; in_we = 1; in_rd = 4'(i + 1); in_alu = 32'h100 + 32'(i);
            tick();
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'(i + 1) || rf_wdata !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL b2b[%0d]: got %b/%h/%h want 1/%h/%h", i, rf_we, rf_waddr, rf_wdata, 4'(i + 1), 32'h100 + 32'(i));
            end
        end
        idle_in();
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", rf_we); end
    endtask

    task automatic test_late_mem();
        int busy = 0;
        apply_reset();
        drive_load(1'b0, 32'h0, 2'd1, 1'b0, 2'd2, 4'd7);
        tick();
        idle_in();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL late_no_write: got %b want 0", rf_we); end
        for (int i = 0; i < 3; i++) begin
            if (in_ready === 1'b0) busy++;
            if (i == 2) begin mem_valid = 1; mem_rdata = 32'h1234_5678; end
            tick();
        end
        idle_in();
        checks++; if (busy !== 3) begin errors++; $display("FAIL late_busy: got %0d want 3", busy); end
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd7) begin errors++; $display("FAIL late_we: got %b/%h want 1/7", rf_we, rf_waddr); end
        checks++; if (rf_wdata !== 32'h0000_1234) begin errors++; $display("FAIL late_data: got %h want 00001234", rf_wdata); end
        checks++; if (wait_cycles !== 16'd3) begin errors++; $display("FAIL late_wait: got %0d want 3", wait_cycles); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL late_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_timeout();
        int n = 0;
        int bad = 0;
        apply_reset();
        drive_load(1'b0, 32'h0, 2'd2, 1'b0, 2'd0, 4'd3);
        tick();
        idle_in();
        while (in_ready !== 1'b1 && n < 10) begin
            if (rf_we !== 1'b0 || err_timeout !== 1'b0) bad++;
            tick();
            n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL tmo_cycles: got %0d want 4", n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL tmo_early: got %0d bad cycles want 0", bad); end
        checks++; if (err_timeout !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL tmo_flag: got %b/%b want 1/0", err_timeout, rf_we); end
        checks++; if (wait_cycles !== 16'd4) begin errors++; $display("FAIL tmo_wait: got %0d want 4", wait_cycles); end
        in_valid = 1; in_sel = 2'd0; in_we = 1; in_rd = 4'd6; in_alu = 32'h66;
        tick();
        idle_in();
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'h66 || err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b/%h/%b want 1/66/1", rf_we, rf_wdata, err_timeout); end
    endtask

    task automatic test_flush_misalign();
        apply_reset();
        drive_load(1'b0, 32'h0, 2'd2, 1'b0, 2'd0, 4'd5);
        tick();
        idle_in();
        flush = 1; mem_valid = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        idle_in();
        checks++; if (rf_we !== 1'b0 || err_timeout !== 1'b0 || err_misalign !== 1'b0) begin errors++; $display("FAIL flush_wait: got %b/%b/%b want 0/0/0", rf_we, err_timeout, err_misalign); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL flush_late_write: got %b want 0", rf_we); end
        in_valid = 1; in_sel = 2'd0; in_we = 1; in_rd = 4'd4; in_alu = 32'h44; flush = 1;
        tick();
        idle_in();
        checks++; if (rf_we !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle: got %b/%b want 0/1", rf_we, in_ready); end
        drive_load(1'b1, 32'h1234_5678, 2'd1, 1'b0, 2'd1, 4'd5);
        tick();
        idle_in();
        checks++; if (err_misalign !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL misalign_imm: got %b/%b want 1/0", err_misalign, rf_we); end
        tick();
        checks++; if (err_misalign !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got %b want 0", err_misalign); end
        drive_load(1'b0, 32'h0, 2'd2, 1'b0, 2'd2, 4'd5);
        tick();
        idle_in();
        mem_valid = 1; mem_rdata = 32'hCAFE_F00D;
        tick();
        idle_in();
        checks++; if (err_misalign !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL misalign_late: got %b/%b want 1/0", err_misalign, rf_we); end
    endtask

    task automatic test_zero_reg();
        apply_reset();
        in_valid = 1; in_sel = 2'd0; in_we = 1; in_rd = 4'd0; in_alu = 32'h55;
        tick();
        checks++; if (rf_we !== 1'b0 || rf_wdata !== 32'h55) begin errors++; $display("FAIL zero_reg: got %b/%h want 0/55", rf_we, rf_wdata); end
        in_we = 0; in_rd = 4'd4; in_alu = 32'h99;
        tick();
        idle_in();
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 4'd4 || rf_wdata !== 32'h99) begin errors++; $display("FAIL no_we: got %b/%h/%h want 0/4/99", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        drive_load(1'b0, 32'h0, 2'd2, 1'b0, 2'd0, 4'd8);
        tick();
        idle_in();
        tick();
        rst = 1; mem_valid = 1; mem_rdata = 32'h1111_2222;
        tick();
        checks++; if (rf_we !== 1'b0 || rf_wdata !== 32'h0 || wait_cycles !== 16'h0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got %b/%h/%h/%b want 0/0/0/0", rf_we, rf_wdata, wait_cycles, err_timeout);
        end
        rst = 0;
        idle_in();
        tick();
        checks++; if (rf_we !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_after: got %b/%b want 0/1", rf_we, in_ready); end
        in_valid = 1; in_sel = 2'd0; in_we = 1; in_rd = 4'd9; in_alu = 32'hABC;
        tick();
        idle_in();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd9 || rf_wdata !== 32'hABC) begin errors++; $display("FAIL rst_mid_next: got %b/%h/%h want 1/9/abc", rf_we, rf_waddr, rf_wdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        idle_in();
        rst = 0;
        test_reset();
        test_alu_select();
        test_load_immediate();
        test_back_to_back();
        test_late_mem();
        test_timeout();
        test_flush_misalign();
        test_zero_reg();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
